// File: rtl/seq_env_ctrl_pkg.sv
// Shared types and widths for the step sequencer / envelope controller.
package seq_pkg;

    localparam int AMP_W   = 10;
    localparam int AMP_MAX = 1023;
    localparam int NOTE_W  = 7;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } env_state_t;

endpackage

// File: rtl/seq_env_ctrl_env_gen.sv
// Envelope generator: free-running tick divider, gate edge detect, ADSR state machine.
// SEQ_RELEASE_EN selects a release ramp; without it a gate fall zeroes amp at once.
module env_gen
    import seq_pkg::*;
#(
    parameter int ENV_DIV     = 4800,
    parameter int ATTACK_INC  = 32,
    parameter int DECAY_DEC   = 8,
    parameter int SUSTAIN_LVL = 768
`ifdef SEQ_RELEASE_EN
    ,
    parameter int RELEASE_DEC = 4
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             gate,
    output logic [AMP_W-1:0] amp,
    output logic [2:0]       state_dbg
);

    localparam int               DIV_W    = (ENV_DIV > 1) ? $clog2(ENV_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(ENV_DIV - 1);
    localparam logic [10:0]      ATK      = 11'(ATTACK_INC);
    localparam logic [10:0]      TOP      = 11'(AMP_MAX);
    localparam logic [10:0]      SUS_THR  = 11'(SUSTAIN_LVL + DECAY_DEC);
    localparam logic [AMP_W-1:0] AMP_FULL = AMP_W'(AMP_MAX);
    localparam logic [AMP_W-1:0] SUS_AMP  = AMP_W'(SUSTAIN_LVL);
    localparam logic [AMP_W-1:0] DEC_AMP  = AMP_W'(DECAY_DEC);
`ifdef SEQ_RELEASE_EN
    localparam logic [10:0]      REL_THR  = 11'(RELEASE_DEC);
    localparam logic [AMP_W-1:0] REL_AMP  = AMP_W'(RELEASE_DEC);
`endif

    logic [DIV_W-1:0] r_div;
    logic             r_gate_d;
    logic [AMP_W-1:0] r_amp;
    env_state_t       r_state;
    env_state_t       w_state;
    logic             w_tick;
    logic             w_rise;
    logic             w_fall;
    logic             w_kill;
    logic [10:0]      w_amp_x;
    logic [10:0]      w_sum;

    assign w_tick    = (r_div == DIV_LAST);
    assign w_rise    = gate & ~r_gate_d;
    assign w_fall    = ~gate & r_gate_d;
    assign w_amp_x   = {1'b0, r_amp};
    assign w_sum     = w_amp_x + ATK;
    assign amp       = r_amp;
    assign state_dbg = r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div    <= '0;
            r_gate_d <= 1'b0;
        end else begin
            r_gate_d <= gate;
            r_div    <= w_tick ? '0 : r_div + DIV_W'(1);
        end
    end

    // Gate edges resolve first; a coincident env tick then acts on the new state.
    always_comb begin
        w_state = r_state;
        w_kill  = 1'b0;
        if (w_rise) begin
            w_state = ATTACK;
        end else if (w_fall && (r_state == ATTACK || r_state == DECAY || r_state == SUSTAIN)) begin
`ifdef SEQ_RELEASE_EN
            w_state = RELEASE;
`else
            w_state = IDLE;
            w_kill  = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_amp   <= '0;
        end else begin
            r_state <= w_state;
            if (w_tick) begin
                case (w_state)
                    ATTACK: begin
                        if (w_sum >= TOP) begin
                            r_amp   <= AMP_FULL;
                            r_state <= DECAY;
                        end else begin
                            r_amp <= w_sum[AMP_W-1:0];
                        end
                    end
                    DECAY: begin
                        if (w_amp_x <= SUS_THR) begin
                            r_amp   <= SUS_AMP;
                            r_state <= SUSTAIN;
                        end else begin
                            r_amp <= r_amp - DEC_AMP;
                        end
                    end
`ifdef SEQ_RELEASE_EN
                    RELEASE: begin
                        if (w_amp_x <= REL_THR) begin
                            r_amp   <= '0;
                            r_state <= IDLE;
                        end else begin
                            r_amp <= r_amp - REL_AMP;
                        end
                    end
`endif
                    default: r_amp <= r_amp;
                endcase
            end
            if (w_kill) begin
                r_amp <= '0;
            end
        end
    end

endmodule

// File: rtl/seq_env_ctrl.sv
// 8-step note sequencer with pattern RAM driving the envelope generator.
// SEQ_RELEASE_EN enables the release ramp in env_gen.
module seq_env_ctrl
    import seq_pkg::*;
#(
    parameter int STEPS       = 8,
    parameter int STEP_TICKS  = 6_000_000,
    parameter int GATE_TICKS  = 3_000_000,
    parameter int ENV_DIV     = 4800,
    parameter int ATTACK_INC  = 32,
    parameter int DECAY_DEC   = 8,
    parameter int SUSTAIN_LVL = 768
`ifdef SEQ_RELEASE_EN
    ,
    parameter int RELEASE_DEC = 4
`endif
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     run,
    input  logic                     wr_en,
    input  logic [$clog2(STEPS)-1:0] wr_addr,
    input  logic [7:0]               wr_data,
    output logic                     gate,
    output logic [NOTE_W-1:0]        note,
    output logic [AMP_W-1:0]         amp,
    output logic [$clog2(STEPS)-1:0] step,
    output logic                     step_stb,
    output logic [2:0]               env_state
);

    localparam int            SW        = $clog2(STEPS);
    localparam int            TW        = $clog2(STEP_TICKS);
    localparam logic [TW-1:0] TICK_LAST = TW'(STEP_TICKS - 1);
    localparam logic [TW-1:0] GATE_END  = TW'(GATE_TICKS);

    logic [7:0]        r_pat [STEPS];
    logic [TW-1:0]     r_tick;
    logic [SW-1:0]     r_step;
    logic              r_gate;
    logic              r_stb;
    logic [NOTE_W-1:0] r_note;

    assign gate     = r_gate;
    assign note     = r_note;
    assign step     = r_step;
    assign step_stb = r_stb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STEPS; i++) begin
                r_pat[i] <= '0;
            end
        end else if (wr_en) begin
            r_pat[wr_addr] <= wr_data;
        end
    end

    // The slot is only read at step start, so a write to the playing step waits a full pass.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick <= '0;
            r_step <= '0;
            r_gate <= 1'b0;
            r_stb  <= 1'b0;
            r_note <= '0;
        end else if (!run) begin
            r_tick <= '0;
            r_step <= '0;
            r_gate <= 1'b0;
            r_stb  <= 1'b0;
        end else begin
            r_stb <= (r_tick == '0);
            if (r_tick == '0) begin
                r_note <= r_pat[r_step][NOTE_W-1:0];
                r_gate <= r_pat[r_step][7];
            end else if (r_tick == GATE_END) begin
                r_gate <= 1'b0;
            end
            if (r_tick == TICK_LAST) begin
                r_tick <= '0;
                r_step <= r_step + 1'b1;
            end else begin
                r_tick <= r_tick + 1'b1;
            end
        end
    end

    env_gen #(
        .ENV_DIV     (ENV_DIV),
        .ATTACK_INC  (ATTACK_INC),
        .DECAY_DEC   (DECAY_DEC),
        .SUSTAIN_LVL (SUSTAIN_LVL)
`ifdef SEQ_RELEASE_EN
        ,
        .RELEASE_DEC (RELEASE_DEC)
`endif
    ) u_env (
        .clk       (clk),
        .rst       (rst),
        .gate      (r_gate),
        .amp       (amp),
        .state_dbg (env_state)
    );

endmodule

// File: tb/tb_seq_env_ctrl.sv
// Bench for seq_env_ctrl: a short-gate instance (table + cycle checks) and a
// long-gate instance that reaches sustain, both fed the same inputs.
module tb_seq_env_ctrl;
    import seq_pkg::*;

    logic       clk;
    logic       rst;
    logic       run;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;

    logic       gate,   l_gate;
    logic [6:0] note,   l_note;
    logic [9:0] amp,    l_amp;
    logic [2:0] step,   l_step;
    logic       stb,    l_stb;
    logic [2:0] est,    l_est;

    int n_vec = 0;
    int n_err = 0;

    logic [9:0] exp_q[$];
    logic [9:0] lexp_q[$];
    logic       mon_en = 1'b0;
    logic [9:0] mon_last = '0;
    logic [9:0] lmon_last = '0;

    seq_env_ctrl #(
        .STEPS(8), .STEP_TICKS(16), .GATE_TICKS(8), .ENV_DIV(2),
        .ATTACK_INC(256), .DECAY_DEC(64), .SUSTAIN_LVL(768)
`ifdef SEQ_RELEASE_EN
        , .RELEASE_DEC(128)
`endif
    ) u_dut (
        .clk(clk), .rst(rst), .run(run), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .gate(gate), .note(note), .amp(amp), .step(step),
        .step_stb(stb), .env_state(est)
    );

    seq_env_ctrl #(
        .STEPS(8), .STEP_TICKS(64), .GATE_TICKS(40), .ENV_DIV(2),
        .ATTACK_INC(256), .DECAY_DEC(64), .SUSTAIN_LVL(768)
`ifdef SEQ_RELEASE_EN
        , .RELEASE_DEC(128)
`endif
    ) u_long (
        .clk(clk), .rst(rst), .run(run), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .gate(l_gate), .note(l_note), .amp(l_amp), .step(l_step),
        .step_stb(l_stb), .env_state(l_est)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        run     = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // amplitude scoreboards: every change of amp must match the next queued value
    always @(negedge clk) begin : mon_short
        logic [9:0] e;
        if (mon_en && amp != mon_last) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL amp_seq: got %0d, required no further change", amp);
            end else begin
                e = exp_q.pop_front();
                if (amp != e) begin
                    n_err++;
                    $display("FAIL amp_seq: got %0d, required %0d", amp, e);
                end
            end
            mon_last = amp;
        end
    end

    always @(negedge clk) begin : mon_long
        logic [9:0] e;
        if (mon_en && l_amp != lmon_last) begin
            n_vec++;
            if (lexp_q.size() == 0) begin
                n_err++;
                $display("FAIL long_amp_seq: got %0d, required no further change", l_amp);
            end else begin
                e = lexp_q.pop_front();
                if (l_amp != e) begin
                    n_err++;
                    $display("FAIL long_amp_seq: got %0d, required %0d", l_amp, e);
                end
            end
            lmon_last = l_amp;
        end
    end

    typedef struct {
        logic       run;
        logic       wr_en;
        logic [2:0] wr_addr;
        logic [7:0] wr_data;
        logic       exp_gate;
        logic [6:0] exp_note;
        logic [2:0] exp_step;
        logic       exp_stb;
        logic [9:0] exp_amp;
    } vec_t;

    vec_t tbl [13];

    initial begin : main
        int j;
        int exp_note;
        rst = 1'b1; run = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;

        // table: write slots 3 and 0, idle one cycle, then run step 0 up to the gate fall
        tbl[0]  = '{1'b0, 1'b1, 3'd3, 8'h3C, 1'b0, 7'd0,  3'd0, 1'b0, 10'd0};
        tbl[1]  = '{1'b0, 1'b1, 3'd0, 8'hC5, 1'b0, 7'd0,  3'd0, 1'b0, 10'd0};
        tbl[2]  = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 7'd0,  3'd0, 1'b0, 10'd0};
        tbl[3]  = '{1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 7'd69, 3'd0, 1'b1, 10'd0};
        tbl[4]  = '{1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 7'd69, 3'd0, 1'b0, 10'd0};
        tbl[5]  = '{1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 7'd69, 3'd0, 1'b0, 10'd256};
        tbl[6]  = '{1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 7'd69, 3'd0, 1'b0, 10'd256};
        tbl[7]  = '{1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 7'd69, 3'd0, 1'b0, 10'd512};
        tbl[8]  = '{1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 7'd69, 3'd0, 1'b0, 10'd512};
        tbl[9]  = '{1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 7'd69, 3'd0, 1'b0, 10'd768};
        tbl[10] = '{1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 7'd69, 3'd0, 1'b0, 10'd768};
        tbl[11] = '{1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 7'd69, 3'd0, 1'b0, 10'd1023};
`ifdef SEQ_RELEASE_EN
        tbl[12] = '{1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 7'd69, 3'd0, 1'b0, 10'd1023};
`else
        tbl[12] = '{1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 7'd69, 3'd0, 1'b0, 10'd0};
`endif

        // reset state
        do_reset();
        chk("rst_gate", gate, 0);
        chk("rst_note", note, 0);
        chk("rst_step", step, 0);
        chk("rst_stb", stb, 0);
        chk("rst_amp", amp, 0);
        chk("rst_state", est, IDLE);

        // empty pattern: strobe every 16 cycles, step wraps 7 -> 0, no gate or amp
        run = 1'b1;
        for (int k = 0; k < 132; k++) begin
            cyc();
            chk($sformatf("empty_step k=%0d", k), step, ((k + 1) / 16) % 8);
            chk($sformatf("empty_stb k=%0d", k), stb, (k % 16 == 0) ? 1 : 0);
            chk($sformatf("empty_gate k=%0d", k), gate, 0);
            chk($sformatf("empty_amp k=%0d", k), amp, 0);
        end

        // pattern playback with envelope scoreboards
        do_reset();
`ifdef SEQ_RELEASE_EN
        exp_q  = '{256, 512, 768, 1023, 895, 767, 639, 511, 383, 255, 127, 0};
        lexp_q = '{256, 512, 768, 1023, 959, 895, 831, 768, 640, 512, 384, 256, 128, 0};
`else
        exp_q  = '{256, 512, 768, 1023, 0};
        lexp_q = '{256, 512, 768, 1023, 959, 895, 831, 768, 0};
`endif
        mon_last  = '0;
        lmon_last = '0;
        mon_en    = 1'b1;
        for (int i = 0; i < 13; i++) begin
            run     = tbl[i].run;
            wr_en   = tbl[i].wr_en;
            wr_addr = tbl[i].wr_addr;
            wr_data = tbl[i].wr_data;
            cyc();
            chk($sformatf("tbl_gate v%0d", i), gate, tbl[i].exp_gate);
            chk($sformatf("tbl_note v%0d", i), note, tbl[i].exp_note);
            chk($sformatf("tbl_step v%0d", i), step, tbl[i].exp_step);
            chk($sformatf("tbl_stb v%0d", i), stb, tbl[i].exp_stb);
            chk($sformatf("tbl_amp v%0d", i), amp, tbl[i].exp_amp);
        end

        // k counts edges since the step-0 start; slot 3 is rewritten while step 3 plays
        for (int k = 10; k < 212; k++) begin
            wr_en   = (k == 51);
            wr_addr = 3'd3;
            wr_data = 8'h03;
            cyc();
            j = (k / 16) % 8;
            exp_note = (j == 0) ? 69 : (j == 3) ? ((k < 128) ? 60 : 3) : 0;
            chk($sformatf("play_step k=%0d", k), step, ((k + 1) / 16) % 8);
            chk($sformatf("play_stb k=%0d", k), stb, (k % 16 == 0) ? 1 : 0);
            chk($sformatf("play_gate k=%0d", k), gate, (j == 0 && k % 16 < 8) ? 1 : 0);
            chk($sformatf("play_note k=%0d", k), note, exp_note);
            if (k == 60) begin
                chk("env_idle", est, IDLE);
                chk("long_env_idle", l_est, IDLE);
                chk("amp_q_drained", exp_q.size(), 0);
                chk("long_amp_q_drained", lexp_q.size(), 0);
                mon_en = 1'b0;
            end
        end

        // run dropped at tick 4 of step 5
        run = 1'b0;
        cyc();
        chk("drop_gate", gate, 0);
        chk("drop_step", step, 0);
        chk("drop_stb", stb, 0);
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk($sformatf("held_step k=%0d", k), step, 0);
            chk($sformatf("held_stb k=%0d", k), stb, 0);
        end

        // restart: step 0 plays again on the first edge with run high
        run = 1'b1;
        cyc();
        chk("restart_stb", stb, 1);
        chk("restart_gate", gate, 1);
        chk("restart_note", note, 69);
        chk("restart_step", step, 0);
        repeat (4) cyc();
        chk("long_attacking", l_est, ATTACK);

        // asynchronous reset mid-attack
        rst = 1'b1;
        #1;
        chk("arst_gate", gate, 0);
        chk("arst_note", note, 0);
        chk("arst_step", step, 0);
        chk("arst_stb", stb, 0);
        chk("arst_amp", amp, 0);
        chk("arst_long_gate", l_gate, 0);
        chk("arst_long_note", l_note, 0);
        chk("arst_long_step", l_step, 0);
        chk("arst_long_stb", l_stb, 0);
        chk("arst_long_amp", l_amp, 0);
        @(negedge clk);
        rst = 1'b0;

        // pattern RAM was cleared: step 0 is now a rest
        for (int k = 0; k < 8; k++) begin
            cyc();
            chk($sformatf("cleared_stb k=%0d", k), stb, (k == 0) ? 1 : 0);
            chk($sformatf("cleared_gate k=%0d", k), gate, 0);
            chk($sformatf("cleared_note k=%0d", k), note, 0);
            chk($sformatf("cleared_amp k=%0d", k), amp, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
